hex_count_display: RTL and testbench
====================================

HEX_COUNT_DISPLAY -- requirements
Module: hex_count_display

Interface
REQ-001 Parameter CNT_W, default 9, sets the binary input width.
REQ-002 Parameter DIGITS, default 3, sets the number of decimal digits; the design SHALL require 2^CNT_W-1 <= 10^DIGITS-1.
REQ-003 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 value  input  CNT_W  binary count to display, unsigned.
REQ-006 value_vld  input  1  one-cycle strobe that samples value.
REQ-007 busy  output  1  high while a conversion is in progress.
REQ-008 done  output  1  one-cycle pulse when the segment outputs update.
REQ-009 HEX  output  DIGITS*7  active-low 7-segment patterns; digit 0 (units) in bits [6:0]; segment order a..g in bit 0..6.

Function
REQ-010 FSM states: IDLE, SHIFT, DONE.
REQ-011 IDLE + value_vld at edge N: value latched; shift register loaded; state becomes SHIFT; busy high from N+1.
REQ-012 SHIFT: sequential double-dabble, one bit per cycle, MSB first, exactly CNT_W cycles.
REQ-013 Double-dabble rule per cycle: each BCD nibble >= 5 gets +3 before the left shift; nibble arithmetic 4 bits, no carry out beyond DIGITS nibbles.
REQ-014 After the CNT_W-th shift, state becomes DONE. At that edge (N+CNT_W+1), HEX is registered from the BCD result and done is high for exactly one cycle.
REQ-015 DONE returns to IDLE on the next edge; busy SHALL be low in IDLE and in DONE.
REQ-016 HEX SHALL hold its last value between conversions.
REQ-017 value_vld while busy or in DONE: value captured into a one-deep pending register; a later strobe overwrites it (last wins).
REQ-018 Pending valid on exit from DONE: the FSM goes directly to SHIFT with the pending value; no IDLE cycle; pending cleared.
REQ-019 value_vld in the same cycle that pending is consumed: the new value becomes the next pending.
REQ-020 Digit decode: 0-9 map to standard patterns; 0 = 7'b1000000, 8 = 7'b0000000.
REQ-021 Input bits above the value of 10^DIGITS-1 are unreachable by REQ-002; no saturation logic.

Reset
REQ-022 rst high: state IDLE, busy 0, done 0, pending cleared, HEX all ones (all segments off).
REQ-023 rst asserted mid-conversion SHALL abort it; no done pulse is issued and HEX is set to all ones.
REQ-024 value_vld is ignored in any cycle in which rst is high.

Configuration
REQ-025 Macro HEX_BLANK_LZ_EN defined: leading zero digits above digit 0 SHALL be blanked (7'h7F); digit 0 is always shown.
REQ-026 Macro absent: all DIGITS digits SHALL be shown, including leading zeros.

Structure
REQ-027 Shared package hex_disp_pkg SHALL hold the FSM state encoding, the ten segment pattern constants, and the blank constant 7'h7F.
REQ-028 Sub-module seg7_decode (4-bit BCD in, 7-bit active-low out) SHALL be instantiated DIGITS times.

Verification
REQ-029 value=0, strobe at edge 0 -> done at edge 10. HEX = 1000000 x3 without the macro; with HEX_BLANK_LZ_EN, digits 2 and 1 are 7'h7F.
REQ-030 value=511 -> digits 5,1,1. busy is high for edges 1..9 and low at edge 10.
REQ-031 Strobe 123 at edge 0, then strobes 45 at edge 3 and 67 at edge 5 -> 123 is displayed at edge 10; 067 is displayed at edge 20; 45 is never displayed.
REQ-032 Strobe 300, then rst at edge 5 -> no done pulse, HEX all ones, busy 0. A strobe of 7 after reset displays 007 (or blank-blank-7 with the macro).
REQ-033 Sweep 0..511, one strobe per idle period -> every decoded digit triple matches the reference decimal value.
REQ-034 value_vld held high continuously with a constant 42 -> conversions run back-to-back every 10 cycles; done pulses once per conversion; HEX = 042.

Source files
------------

// File: rtl/hex_disp_pkg.sv
// Shared definitions for the hex_count_display block: FSM state encoding and
// active-low 7-segment patterns (bit 0 = segment a, bit 6 = segment g).
package hex_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/hex_count_display_if.sv
// Bus between a count producer (master) and the hex_count_display block (slave).
interface hex_count_display_if #(
  parameter int CNT_W  = 9,
  parameter int DIGITS = 3
);

  // value_vld is a one-cycle strobe with no ready: the slave always accepts it,
  // either starting a conversion or overwriting its one-deep pending slot.
  // busy is advisory only; done pulses for one cycle when HEX changes.
  logic [CNT_W-1:0]    value;
  logic                value_vld;
  logic                busy;
  logic                done;
  logic [DIGITS*7-1:0] HEX;

  modport master (output value, output value_vld, input busy, input done, input HEX);
  modport slave  (input value, input value_vld, output busy, output done, output HEX);

endinterface

// File: rtl/seg7_decode.sv
// One BCD digit to an active-low 7-segment pattern; codes 10-15 are blanked.
module seg7_decode
  import hex_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hex_count_display.sv
// Sequential double-dabble binary-to-BCD converter driving DIGITS 7-segment digits.
// Define HEX_BLANK_LZ_EN to blank leading zero digits (digit 0 always shown).
module hex_count_display
  import hex_disp_pkg::*;
#(
  parameter int CNT_W  = 9,
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  hex_count_display_if.slave  bus,
  output state_t              fsm_state
);

  localparam int BCD_W = DIGITS * 4;
  localparam int CW    = $clog2(CNT_W + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(CNT_W - 1);

  state_t              state;
  logic [CNT_W-1:0]    sh;
  logic [CNT_W-1:0]    pend_val;
  logic                pend_vld;
  logic [BCD_W-1:0]    bcd;
  logic [BCD_W-1:0]    bcd_adj;
  logic [CW-1:0]       cnt;
  logic                busy_q;
  logic                done_q;
  logic [DIGITS*7-1:0] hex_q;
  logic [DIGITS*7-1:0] seg_raw;
  logic [DIGITS*7-1:0] seg_shown;

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    seg7_decode u_dec (
      .bcd (bcd[4*g +: 4]),
      .seg (seg_raw[7*g +: 7])
    );
  end

`ifdef HEX_BLANK_LZ_EN
  logic lead_zero;

  always_comb begin
    seg_shown = seg_raw;
    lead_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      lead_zero = lead_zero && (bcd[4*i +: 4] == 4'd0);
      if (lead_zero) seg_shown[7*i +: 7] = SEG_BLANK;
    end
  end
`else
  always_comb begin
    seg_shown = seg_raw;
  end
`endif

  // busy is the SHIFT state delayed by one edge, so it rises one edge after
  // the strobe is taken and falls on the edge that publishes the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      sh       <= '0;
      pend_val <= '0;
      pend_vld <= 1'b0;
      bcd      <= '0;
      cnt      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hex_q    <= '1;
    end else begin
      done_q <= 1'b0;
      busy_q <= (state == ST_SHIFT);
      case (state)
        ST_IDLE: begin
          if (bus.value_vld || pend_vld) begin
            sh       <= bus.value_vld ? bus.value : pend_val;
            bcd      <= '0;
            cnt      <= '0;
            pend_vld <= 1'b0;
            state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          bcd <= (bcd_adj << 1) | {{(BCD_W-1){1'b0}}, sh[CNT_W-1]};
          sh  <= sh << 1;
          cnt <= cnt + CW'(1);
          if (cnt == LAST_CNT) state <= ST_DONE;
          if (bus.value_vld) begin
            pend_val <= bus.value;
            pend_vld <= 1'b1;
          end
        end
        ST_DONE: begin
          hex_q  <= seg_shown;
          done_q <= 1'b1;
          if (pend_vld) begin
            sh    <= pend_val;
            bcd   <= '0;
            cnt   <= '0;
            state <= ST_SHIFT;
          end else begin
            state <= ST_IDLE;
          end
          // A strobe on the consuming edge refills the slot just emptied.
          pend_vld <= bus.value_vld;
          if (bus.value_vld) pend_val <= bus.value;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.HEX   = hex_q;
  assign fsm_state = state;

endmodule

// File: tb/tb_hex_count_display.sv
// Self-checking bench for hex_count_display (CNT_W=9, DIGITS=3); honours HEX_BLANK_LZ_EN.
module tb_hex_count_display;
  import hex_disp_pkg::*;

  localparam int CNT_W  = 9;
  localparam int DIGITS = 3;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000, BL = 7'h7F;
  localparam logic [6:0] SEG_TAB [10] = '{S0, S1, S2, S3, S4, S5, S6, S7, S8, S9};

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst;
  state_t fsm_state;

  hex_count_display_if #(.CNT_W(CNT_W), .DIGITS(DIGITS)) bus ();

  hex_count_display #(.CNT_W(CNT_W), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  logic [DIGITS*7-1:0] exp_q[$];

  typedef struct {
    logic [CNT_W-1:0]    value;
    logic [DIGITS*7-1:0] hex_plain;
    logic [DIGITS*7-1:0] hex_blank;
  } vec_t;
  vec_t vecs[7];

  // Reference: decimal digits by division, blanking by magnitude.
  function automatic logic [DIGITS*7-1:0] exp_hex(input int v);
    logic [DIGITS*7-1:0] r;
    int p;
    int d;
    r = '0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      d = (v / p) % 10;
      r[7*i +: 7] = SEG_TAB[d];
`ifdef HEX_BLANK_LZ_EN
      if (i > 0 && v < p) r[7*i +: 7] = 7'h7F;
`endif
      p = p * 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
    else n_pass++;
  endtask

  task automatic fail(input string name, input string detail);
    n_checks++;
    $display("FAIL %s: %s", name, detail);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.done) begin
      done_cnt++;
      if (exp_q.size() == 0) fail("spurious_done", $sformatf("hex=%h with nothing expected", bus.HEX));
      else check("scoreboard_hex", 32'(bus.HEX), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic strobe(input int v);
    bus.value     = CNT_W'(v);
    bus.value_vld = 1'b1;
    tick();
    bus.value_vld = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    repeat (60) begin
      if (fsm_state == ST_IDLE && !bus.busy && !bus.done) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) fail("wait_idle_timeout", "DUT did not return to IDLE within 60 cycles");
  endtask

  task automatic conv_latency(input int v, output int lat);
    exp_q.push_back(exp_hex(v));
    strobe(v);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.done) begin
        lat = i;
        break;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int dc0;
    int busy_seen;
    int done_edges[$];
    logic [DIGITS*7-1:0] want;

    vecs[0] = '{9'd0,   {S0, S0, S0}, {BL, BL, S0}};
    vecs[1] = '{9'd511, {S5, S1, S1}, {S5, S1, S1}};
    vecs[2] = '{9'd7,   {S0, S0, S7}, {BL, BL, S7}};
    vecs[3] = '{9'd42,  {S0, S4, S2}, {BL, S4, S2}};
    vecs[4] = '{9'd100, {S1, S0, S0}, {S1, S0, S0}};
    vecs[5] = '{9'd309, {S3, S0, S9}, {S3, S0, S9}};
    vecs[6] = '{9'd90,  {S0, S9, S0}, {BL, S9, S0}};

    // Reset, with a strobe held during reset that must be ignored.
    rst = 1'b1;
    bus.value = CNT_W'(77);
    bus.value_vld = 1'b1;
    repeat (3) tick();
    check("reset_hex", 32'(bus.HEX), 32'h1FFFFF);
    check("reset_busy", 32'(bus.busy), 0);
    check("reset_done", 32'(bus.done), 0);
    rst = 1'b0;
    bus.value_vld = 1'b0;
    repeat (2) tick();
    check("reset_vld_ignored_state", 32'(fsm_state), 32'(ST_IDLE));
    check("reset_vld_ignored_busy", 32'(bus.busy), 0);

    // Table-driven vectors.
    for (int i = 0; i < 7; i++) begin
      wait_idle();
      conv_latency(int'(vecs[i].value), lat);
`ifdef HEX_BLANK_LZ_EN
      want = vecs[i].hex_blank;
`else
      want = vecs[i].hex_plain;
`endif
      check($sformatf("vec%0d_latency", i), 32'(lat), 10);
      check($sformatf("vec%0d_hex", i), 32'(bus.HEX), 32'(want));
    end

    // busy profile for 511: high at edges 1..9, low at 10.
    wait_idle();
    exp_q.push_back(exp_hex(511));
    strobe(511);
    for (int e = 1; e <= 10; e++) begin
      tick();
      check($sformatf("busy_edge%0d", e), 32'(bus.busy), (e <= 9) ? 1 : 0);
      check($sformatf("done_edge%0d", e), 32'(bus.done), (e == 10) ? 1 : 0);
    end
    wait_idle();
    check("hex_holds_511", 32'(bus.HEX), 32'(exp_hex(511)));

    // 123 at edge 0, 45 at edge 3, 67 at edge 5: 123 then 067; 45 never shown.
    wait_idle();
    exp_q.push_back(exp_hex(123));
    exp_q.push_back(exp_hex(67));
    done_edges.delete();
    for (int t = 0; t <= 25; t++) begin
      bus.value_vld = (t == 0 || t == 3 || t == 5);
      bus.value = (t == 0) ? CNT_W'(123) : (t == 3) ? CNT_W'(45) : CNT_W'(67);
      tick();
      if (bus.done) done_edges.push_back(t);
    end
    bus.value_vld = 1'b0;
    check("pend_done_count", 32'(done_edges.size()), 2);
    if (done_edges.size() == 2) begin
      check("pend_first_edge", 32'(done_edges[0]), 10);
      check("pend_second_edge", 32'(done_edges[1]), 20);
    end

    // Abort by reset at edge 5, strobe during reset ignored.
    wait_idle();
    dc0 = done_cnt;
    strobe(300);
    repeat (4) tick();
    rst = 1'b1;
    bus.value = CNT_W'(5);
    bus.value_vld = 1'b1;
    tick();
    rst = 1'b0;
    bus.value_vld = 1'b0;
    check("abort_hex", 32'(bus.HEX), 32'h1FFFFF);
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_done", 32'(bus.done), 0);
    busy_seen = 0;
    repeat (15) begin
      tick();
      busy_seen += int'(bus.busy);
    end
    check("abort_no_busy", 32'(busy_seen), 0);
    check("abort_no_done", 32'(done_cnt - dc0), 0);
    conv_latency(7, lat);
    check("after_abort_latency", 32'(lat), 10);
`ifdef HEX_BLANK_LZ_EN
    check("after_abort_hex", 32'(bus.HEX), 32'(vecs[2].hex_blank));
`else
    check("after_abort_hex", 32'(bus.HEX), 32'(vecs[2].hex_plain));
`endif

    // value_vld held high with 42 for edges 0..49: six conversions, one per 10 edges.
    wait_idle();
    repeat (6) exp_q.push_back(exp_hex(42));
    done_edges.delete();
    bus.value = CNT_W'(42);
    for (int t = 0; t < 70; t++) begin
      bus.value_vld = (t < 50);
      tick();
      if (bus.done) done_edges.push_back(t);
    end
    bus.value_vld = 1'b0;
    check("b2b_done_count", 32'(done_edges.size()), 6);
    foreach (done_edges[k]) check($sformatf("b2b_done%0d_edge", k), 32'(done_edges[k]), 32'(10 * (k + 1)));
    check("b2b_hex", 32'(bus.HEX), 32'(exp_hex(42)));

    // Random overlapping strobes: the last strobe during a conversion wins.
    for (int it = 0; it < 10; it++) begin
      int a;
      int b;
      wait_idle();
      a = int'($urandom_range(0, 511));
      b = -1;
      dc0 = done_cnt;
      exp_q.push_back(exp_hex(a));
      strobe(a);
      for (int e = 1; e <= 22; e++) begin
        if (e == 10 && b >= 0) exp_q.push_back(exp_hex(b));
        if (e <= 9 && $urandom_range(0, 2) == 0) begin
          b = int'($urandom_range(0, 511));
          bus.value = CNT_W'(b);
          bus.value_vld = 1'b1;
        end
        tick();
        bus.value_vld = 1'b0;
      end
      check($sformatf("overlap%0d_done_count", it), 32'(done_cnt - dc0), (b >= 0) ? 2 : 1);
    end

    // Random idle-spaced values.
    for (int it = 0; it < 30; it++) begin
      int v;
      wait_idle();
      repeat ($urandom_range(0, 3)) tick();
      v = int'($urandom_range(0, 511));
      conv_latency(v, lat);
      check($sformatf("rand_latency_%0d", v), 32'(lat), 10);
    end

    // Full sweep, every digit triple checked by the scoreboard.
    for (int v = 0; v < 512; v++) begin
      wait_idle();
      conv_latency(v, lat);
      check($sformatf("sweep_latency_%0d", v), 32'(lat), 10);
    end

    wait_idle();
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
